// File: rtl/calc_nport.sv
// calc_nport: multi-port add/sub/shift calculator.
// Each port captures {cmd, op1, op2} over two cycles into a small per-port
// queue. A round-robin arbiter issues one queue head per cycle into a
// two-stage execute pipeline, and the result is pulsed back on the origin port.
// Optional feature macro: CALC_NPORT_SHIFT_EN (builds the shift-left/right commands).
module calc_nport #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 2
) (
    input  logic                     c_clk,
    input  logic                     reset,
    input  logic [NPORTS*4-1:0]      req_cmd_in,
    input  logic [NPORTS*DATA_W-1:0] req_data_in,
    output logic [NPORTS-1:0]        req_busy,
    output logic [NPORTS*2-1:0]      out_resp,
    output logic [NPORTS*DATA_W-1:0] out_data
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
`ifdef CALC_NPORT_SHIFT_EN
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;
    localparam int         SW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`endif
    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_OVF = 2'd2;
    localparam logic [1:0] RESP_INV = 2'd3;

    typedef enum logic {S_IDLE, S_OP2} state_t;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_t;

    state_t            state     [NPORTS];
    state_t            state_nxt [NPORTS];
    logic [3:0]        cap_cmd   [NPORTS];
    logic [DATA_W-1:0] cap_op1   [NPORTS];
    req_t              q         [NPORTS][QDEPTH];
    logic [CW-1:0]     q_cnt     [NPORTS];
    logic [CW-1:0]     wr_idx    [NPORTS];
    logic [NPORTS-1:0] accept, push, pop;

    logic [PW-1:0]     rr_ptr, grant_port;
    logic              grant_vld;
    req_t              grant_req;

    logic              s1_vld;
    logic [PW-1:0]     s1_port;
    req_t              s1_req;
    logic [DATA_W:0]   ex_sum;
    logic [1:0]        ex_resp;
    logic [DATA_W-1:0] ex_data;

    // Round-robin pick: first non-empty queue at or after rr_ptr, then wrap
    always_comb begin
        grant_vld  = 1'b0;
        grant_port = '0;
        grant_req  = '0;
        pop        = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (!grant_vld && q_cnt[p] != '0 && PW'(p) >= rr_ptr) begin
                grant_vld  = 1'b1;
                grant_port = PW'(p);
                grant_req  = q[p][0];
                pop[p]     = 1'b1;
            end
        end
        for (int p = 0; p < NPORTS; p++) begin
            if (!grant_vld && q_cnt[p] != '0 && PW'(p) < rr_ptr) begin
                grant_vld  = 1'b1;
                grant_port = PW'(p);
                grant_req  = q[p][0];
                pop[p]     = 1'b1;
            end
        end
    end

    // Capture FSM next state; busy counts a request still collecting op2
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            state_nxt[p] = state[p];
            accept[p]    = 1'b0;
            push[p]      = 1'b0;
            req_busy[p]  = !reset &&
                (({1'b0, q_cnt[p]} + (CW+1)'(state[p] == S_OP2)) == (CW+1)'(QDEPTH));
            wr_idx[p]    = q_cnt[p] - CW'(pop[p]);
            case (state[p])
                S_IDLE: begin
                    if (req_cmd_in[4*p +: 4] != 4'd0 && !req_busy[p]) begin
                        accept[p]    = 1'b1;
                        state_nxt[p] = S_OP2;
                    end
                end
                S_OP2: begin
                    push[p]      = 1'b1;
                    state_nxt[p] = S_IDLE;
                end
                default: state_nxt[p] = S_IDLE;
            endcase
        end
    end

    // Capture FSM state register and command/operand-1 latch
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (reset) state[p] <= S_IDLE;
            else       state[p] <= state_nxt[p];
            if (accept[p]) begin
                cap_cmd[p] <= req_cmd_in[4*p +: 4];
                cap_op1[p] <= req_data_in[p*DATA_W +: DATA_W];
            end
        end
    end

    // Per-port shift queue: head at entry 0, pop shifts down, push lands after the tail
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (reset) q_cnt[p] <= '0;
            else       q_cnt[p] <= q_cnt[p] + CW'(push[p]) - CW'(pop[p]);
            if (pop[p])
                for (int i = 0; i < QDEPTH - 1; i++) q[p][i] <= q[p][i+1];
            if (push[p])
                for (int i = 0; i < QDEPTH; i++)
                    if (wr_idx[p] == CW'(i))
                        q[p][i] <= {cap_cmd[p], cap_op1[p], req_data_in[p*DATA_W +: DATA_W]};
        end
    end

    // Arbiter pointer moves to the port after the last grant
    always_ff @(posedge c_clk) begin
        if (reset)          rr_ptr <= '0;
        else if (grant_vld) rr_ptr <= (grant_port == PW'(NPORTS - 1)) ? '0 : grant_port + 1'b1;
    end

    // Execute stage 1: hold the granted request
    always_ff @(posedge c_clk) begin
        if (reset) s1_vld <= 1'b0;
        else       s1_vld <= grant_vld;
        s1_port <= grant_port;
        s1_req  <= grant_req;
    end

    // Result and response code for the request in stage 1
    always_comb begin
        ex_sum  = {1'b0, s1_req.op1} + {1'b0, s1_req.op2};
        ex_resp = RESP_INV;
        ex_data = '0;
        case (s1_req.cmd)
            CMD_ADD: begin
                if (ex_sum[DATA_W]) ex_resp = RESP_OVF;
                else begin
                    ex_resp = RESP_OK;
                    ex_data = ex_sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (s1_req.op2 > s1_req.op1) ex_resp = RESP_OVF;
                else begin
                    ex_resp = RESP_OK;
                    ex_data = s1_req.op1 - s1_req.op2;
                end
            end
`ifdef CALC_NPORT_SHIFT_EN
            CMD_SHL: begin
                ex_resp = RESP_OK;
                ex_data = s1_req.op1 << s1_req.op2[SW-1:0];
            end
            CMD_SHR: begin
                ex_resp = RESP_OK;
                ex_data = s1_req.op1 >> s1_req.op2[SW-1:0];
            end
`endif
            default: ;
        endcase
    end

    // Execute stage 2: one-cycle response pulse on the originating port
    always_ff @(posedge c_clk) begin
        out_resp <= '0;
        out_data <= '0;
        if (!reset && s1_vld) begin
            out_resp[2*s1_port +: 2]           <= ex_resp;
            out_data[s1_port*DATA_W +: DATA_W] <= ex_data;
        end
    end

endmodule

// File: tb/tb_calc_nport.sv
// tb_calc_nport: directed stimulus for calc_nport, a queue-based reference
// model compared against the DUT every cycle, plus hand-computed expectations.
module tb_calc_nport;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int QD = 2;

    logic             c_clk = 1'b0;
    logic             reset = 1'b1;
    logic [NP*4-1:0]  req_cmd_in = '0;
    logic [NP*DW-1:0] req_data_in = '0;
    logic [NP-1:0]    req_busy;
    logic [NP*2-1:0]  out_resp;
    logic [NP*DW-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int ec = 0;          // number of rising edges seen so far
    bit busy0_seen = 0;

    calc_nport #(.NPORTS(NP), .DATA_W(DW), .QDEPTH(QD)) dut (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .req_busy(req_busy), .out_resp(out_resp), .out_data(out_data)
    );

    always #5 c_clk = ~c_clk;

    typedef struct packed { logic [3:0] cmd; logic [DW-1:0] a; logic [DW-1:0] b; } mreq_t;
    typedef struct packed { int due; int port; logic [1:0] resp; logic [DW-1:0] data; } mres_t;
    typedef struct packed { int cyc; logic [1:0] resp; logic [DW-1:0] data; } lg_t;

    // reference model state
    mreq_t        mq [NP][$];
    bit           mpend [NP];
    logic [3:0]   mcmd [NP];
    logic [DW-1:0] mop1 [NP];
    bit           mfull [NP];
    int           drops [NP];
    mres_t        mfl [$];
    logic [1:0]   eresp [NP];
    logic [DW-1:0] edata [NP];
    int           mptr, mp;
    bit           mgot;
    mres_t        mr;
    mreq_t        mrq;
    logic [3:0]   mc;
    logic [DW-1:0] md;

    lg_t dlog [NP][$];
    lg_t clg;

    function automatic mres_t calc(input mreq_t r, input int port, input int due);
        mres_t o;
        longint unsigned s;
        o.due  = due;
        o.port = port;
        o.resp = 2'd3;
        o.data = '0;
        s = 64'(r.a) + 64'(r.b);
        case (r.cmd)
            4'd1: if (s >= (64'd1 << DW)) o.resp = 2'd2;
                  else begin o.resp = 2'd1; o.data = s[DW-1:0]; end
            4'd2: if (r.b > r.a) o.resp = 2'd2;
                  else begin o.resp = 2'd1; o.data = r.a - r.b; end
`ifdef CALC_NPORT_SHIFT_EN
            4'd5: begin o.resp = 2'd1; o.data = r.a << r.b[4:0]; end
            4'd6: begin o.resp = 2'd1; o.data = r.a >> r.b[4:0]; end
`endif
            default: ;
        endcase
        return o;
    endfunction

    // Model: on each rising edge, deliver due results, grant one queue head, capture inputs
    initial begin
        mptr = 0;
        for (int p = 0; p < NP; p++) begin
            mpend[p] = 0; drops[p] = 0; eresp[p] = '0; edata[p] = '0;
        end
        forever begin
            @(posedge c_clk);
            ec++;
            for (int p = 0; p < NP; p++) begin eresp[p] = '0; edata[p] = '0; end
            if (reset) begin
                for (int p = 0; p < NP; p++) begin mq[p].delete(); mpend[p] = 0; end
                mptr = 0;
                mfl.delete();
            end else begin
                while (mfl.size() > 0 && mfl[0].due == ec) begin
                    mr = mfl.pop_front();
                    eresp[mr.port] = mr.resp;
                    edata[mr.port] = mr.data;
                end
                for (int p = 0; p < NP; p++)
                    mfull[p] = (mq[p].size() + (mpend[p] ? 1 : 0)) == QD;
                mgot = 0;
                for (int i = 0; i < NP; i++) begin
                    mp = (mptr + i) % NP;
                    if (!mgot && mq[mp].size() > 0) begin
                        mrq = mq[mp].pop_front();
                        mfl.push_back(calc(mrq, mp, ec + 1));
                        mptr = (mp + 1) % NP;
                        mgot = 1;
                    end
                end
                for (int p = 0; p < NP; p++) begin
                    mc = req_cmd_in[4*p +: 4];
                    md = req_data_in[DW*p +: DW];
                    if (mpend[p]) begin
                        mrq = {mcmd[p], mop1[p], md};
                        mq[p].push_back(mrq);
                        mpend[p] = 0;
                    end else if (mc != 4'd0) begin
                        if (mfull[p]) drops[p]++;
                        else begin mpend[p] = 1; mcmd[p] = mc; mop1[p] = md; end
                    end
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge; log DUT responses
    initial begin
        forever begin
            @(negedge c_clk);
            if (ec > 0) begin
                for (int p = 0; p < NP; p++) begin
                    checks++;
                    if (out_resp[2*p +: 2] !== eresp[p] || out_data[DW*p +: DW] !== edata[p]) begin
                        errors++;
                        $display("FAIL out port%0d cyc %0d: got resp %0d data %0h, expected resp %0d data %0h",
                                 p, ec, out_resp[2*p +: 2], out_data[DW*p +: DW], eresp[p], edata[p]);
                    end
                    checks++;
                    if (req_busy[p] !== ((mq[p].size() + (mpend[p] ? 1 : 0)) == QD)) begin
                        errors++;
                        $display("FAIL busy port%0d cyc %0d: got %0b", p, ec, req_busy[p]);
                    end
                    if (out_resp[2*p +: 2] != 2'd0) begin
                        clg.cyc  = ec;
                        clg.resp = out_resp[2*p +: 2];
                        clg.data = out_data[DW*p +: DW];
                        dlog[p].push_back(clg);
                    end
                end
                if (req_busy[0]) busy0_seen = 1;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic lg_t lg(input int p, input int i);
        lg_t x = '0;
        x.cyc = -1;
        if (i < dlog[p].size()) x = dlog[p][i];
        return x;
    endfunction

    task automatic step();
        @(negedge c_clk);
        #1;
        req_cmd_in  = '0;
        req_data_in = '0;
    endtask

    task automatic setp(input int p, input logic [3:0] c, input logic [DW-1:0] d);
        req_cmd_in[4*p +: 4]   = c;
        req_data_in[DW*p +: DW] = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_logs();
        for (int p = 0; p < NP; p++) dlog[p].delete();
    endtask

    // two-cycle request; the command stays on the bus during op2 and must be ignored
    task automatic issue(input int p, input logic [3:0] c, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, output int op2cyc);
        step(); setp(p, c, a);
        step(); setp(p, c, b); op2cyc = ec;
    endtask

    int t, t2;

    initial begin
        // reset state
        idle(3);
        chk("reset_resp", out_resp, 0);
        chk("reset_data_any", |out_data, 0);
        chk("reset_busy", req_busy, 0);
        step(); reset = 1'b0;

        // uncontended add, latency
        clr_logs();
        issue(0, 4'd1, 32'h1, 32'h01FF_FFFF, t);
        idle(6);
        chk("add_count", dlog[0].size(), 1);
        chk("add_resp", lg(0, 0).resp, 1);
        chk("add_data", lg(0, 0).data, 32'h0200_0000);
        chk("add_latency", lg(0, 0).cyc - t, 3);

        // overflow / underflow and their non-overflow neighbours
        clr_logs();
        issue(1, 4'd1, 32'hFFFF_FFFF, 32'h1, t);
        issue(2, 4'd2, 32'h1, 32'hF, t);
        issue(1, 4'd1, 32'hFFFF_FFFE, 32'h1, t);
        issue(2, 4'd2, 32'h10, 32'h3, t);
        idle(6);
        chk("add_ovf_resp", lg(1, 0).resp, 2);
        chk("add_ovf_data", lg(1, 0).data, 0);
        chk("add_max_resp", lg(1, 1).resp, 1);
        chk("add_max_data", lg(1, 1).data, 32'hFFFF_FFFF);
        chk("sub_unf_resp", lg(2, 0).resp, 2);
        chk("sub_unf_data", lg(2, 0).data, 0);
        chk("sub_ok_data", lg(2, 1).data, 32'hD);

        // invalid commands and shifts
        clr_logs();
        issue(3, 4'd3, 32'h5, 32'h6, t);
        issue(3, 4'd4, 32'h5, 32'h6, t);
        issue(3, 4'd5, 32'h1, 32'h4, t);
        issue(3, 4'd6, 32'h80, 32'h3, t);
        issue(3, 4'd15, 32'h1, 32'h1, t);
        idle(6);
        chk("inv_count", dlog[3].size(), 5);
        chk("inv3_resp", lg(3, 0).resp, 3);
        chk("inv4_resp", lg(3, 1).resp, 3);
`ifdef CALC_NPORT_SHIFT_EN
        chk("shl_resp", lg(3, 2).resp, 1);
        chk("shl_data", lg(3, 2).data, 32'h10);
        chk("shr_data", lg(3, 3).data, 32'h10);
`else
        chk("shl_resp", lg(3, 2).resp, 3);
        chk("shl_data", lg(3, 2).data, 0);
        chk("shr_resp", lg(3, 3).resp, 3);
`endif
        chk("inv15_resp", lg(3, 4).resp, 3);

        // all ports at once: round-robin 0,1,2,3 on consecutive cycles
        clr_logs();
        step(); for (int p = 0; p < NP; p++) setp(p, 4'd1, 32'h1000 * (p + 1) + p);
        step(); for (int p = 0; p < NP; p++) setp(p, 4'd0, 32'h1000 * (p + 1) + p);
        t = ec;
        idle(8);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rr_cyc_p%0d", p), lg(p, 0).cyc - t, 3 + p);
            chk($sformatf("rr_data_p%0d", p), lg(p, 0).data, 2 * (32'h1000 * (p + 1) + p));
        end

        // queue fills on port 0 under contention: third add is dropped
        clr_logs();
        busy0_seen = 0;
        for (int p = 0; p < NP; p++) drops[p] = 0;
        step(); for (int p = 1; p < NP; p++) setp(p, 4'd1, 32'd100);
        step(); for (int p = 1; p < NP; p++) setp(p, 4'd0, 32'd1);
                setp(0, 4'd1, 32'd10);
        step(); setp(0, 4'd0, 32'd1);
                for (int p = 1; p < NP; p++) setp(p, 4'd1, 32'd200);
        step(); setp(0, 4'd1, 32'd20);
                for (int p = 1; p < NP; p++) setp(p, 4'd0, 32'd2);
        step(); setp(0, 4'd0, 32'd2);
        step(); setp(0, 4'd1, 32'd30);
        step(); setp(0, 4'd0, 32'd3);
        idle(10);
        chk("busy0_seen", busy0_seen, 1);
        chk("drop_model", drops[0], 1);
        chk("drop_count", dlog[0].size(), 2);
        chk("drop_d0", lg(0, 0).data, 11);
        chk("drop_d1", lg(0, 1).data, 22);
        chk("drop_p1_count", dlog[1].size(), 2);

        // reset one cycle after op2 discards the request; first post-reset cmd accepted
        clr_logs();
        issue(0, 4'd1, 32'd5, 32'd6, t);
        step(); reset = 1'b1;
        step();
        step(); reset = 1'b0; setp(0, 4'd1, 32'd7);
        step(); setp(0, 4'd0, 32'd8); t2 = ec;
        idle(6);
        chk("rst_count", dlog[0].size(), 1);
        chk("rst_data", lg(0, 0).data, 15);
        chk("rst_latency", lg(0, 0).cyc - t2, 3);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
